// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Byte-write and status bundle for the FIFO-buffered UART
//            transmitter.
// Signals  : tx_data_in      [7:0] byte to queue
//            tx_dv_in              write strobe, one byte per high cycle
//            tx_out                serial line, idle high
//            tx_busy_out           frame on the line
//            tx_full_out           FIFO full
//            tx_empty_out          FIFO empty
//            tx_overflow_out       sticky dropped-write flag
// Modports : master - byte producer (drives data/strobe, observes status)
//            slave  - the transmitter itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic [7:0] tx_data_in;
    logic       tx_dv_in;
    logic       tx_out;
    logic       tx_busy_out;
    logic       tx_full_out;
    logic       tx_empty_out;
    logic       tx_overflow_out;

    modport master (
        output tx_data_in,
        output tx_dv_in,
        input  tx_out,
        input  tx_busy_out,
        input  tx_full_out,
        input  tx_empty_out,
        input  tx_overflow_out
    );

    modport slave (
        input  tx_data_in,
        input  tx_dv_in,
        output tx_out,
        output tx_busy_out,
        output tx_full_out,
        output tx_empty_out,
        output tx_overflow_out
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : 8N1 UART transmitter (LSB first) fed by a small byte FIFO so a
//            producer can burst up to FIFO_DEPTH bytes without waiting on
//            the serial line.
// Ports    : clk    - design clock, all logic on posedge
//            reset  - synchronous, active-high; clears FIFO state and aborts
//                     any frame in progress
//            bus    - uart_tx_fifo_if.slave (byte write strobe + status and
//                     the serial line)
// Params   : CLKS_PER_BIT - clk cycles per serial bit (>= 2)
//            FIFO_DEPTH   - FIFO entries (power of 2, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_tx_fifo_if.slave bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_pop;

    state_t state_q;
    state_t state_d;

    // Full/empty come from the registered count, so a write landing in an
    // empty FIFO only becomes poppable on the following cycle.
    assign w_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign w_empty = (count_q == '0);
    assign w_wr_en = bus.tx_dv_in && !w_full;
    assign w_pop   = (state_q == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= bus.tx_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (w_wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Full is judged before the edge, so a write colliding with a
            // pop from a full FIFO is still dropped.
            if (bus.tx_dv_in && w_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------------
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              tx_q;
    logic              tx_d;
    logic              w_baud_last;

    assign w_baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line level is registered from the current state, so tx_out lags
    // the state by one cycle: the pop edge enters START and the line falls
    // one edge later. Every bit still lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                tx_d = 1'b0;
                if (w_baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                tx_d = shift_q[0];
                if (w_baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (w_baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.tx_out          = tx_q;
    assign bus.tx_busy_out     = (state_q != S_IDLE);
    assign bus.tx_full_out     = w_full;
    assign bus.tx_empty_out    = w_empty;
    assign bus.tx_overflow_out = overflow_q;

endmodule
`default_nettype wire
